// File: rtl/mod_shift_pkg.sv
// Shared encodings and defaults for the shift-register block.
package mod_shift_pkg;
    localparam int DW_DEF = 256;
    localparam int WW_DEF = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/mod_shift_ctrl.sv
// Command FSM: accepts commands, sequences multi-cycle shifts, emits done.
module mod_shift_ctrl
    import mod_shift_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cmd_valid,
    input  logic [1:0]    i_cmd_op,
    input  logic [CW-1:0] i_cmd_cnt,
    input  logic          i_stall,
    output logic          o_cmd_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_accept,
    output logic          o_shift_en,
    output logic          o_shift_left
);
    localparam logic [CW-1:0] DW_CNT  = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e        r_state;
    logic [CW-1:0] r_remaining;
    logic          r_done;
    logic          r_left;

    logic          w_accept;
    logic          w_is_shift;
    logic [CW-1:0] w_cnt_clamp;

    assign w_accept    = i_cmd_valid && (r_state == IDLE);
    assign w_is_shift  = (i_cmd_op == OP_SHR) || (i_cmd_op == OP_SHL);
    assign w_cnt_clamp = (i_cmd_cnt > DW_CNT) ? DW_CNT : i_cmd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_left      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    // Zero-count shifts, loads and clears finish at the accept edge.
                    if (w_is_shift && (i_cmd_cnt != '0)) begin
                        r_state     <= SHIFT;
                        r_remaining <= w_cnt_clamp;
                        r_left      <= (i_cmd_op == OP_SHL);
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else if (!i_stall) begin
                r_remaining <= r_remaining - CNT_ONE;
                if (r_remaining == CNT_ONE) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_cmd_ready  = (r_state == IDLE);
    assign o_busy       = (r_state == SHIFT);
    assign o_done       = r_done;
    assign o_accept     = w_accept;
    assign o_shift_en   = (r_state == SHIFT) && !i_stall;
    assign o_shift_left = r_left;
endmodule

// File: rtl/mod_shift_reg.sv
// Wide shift register with word load, clear and multi-cycle serial shifts.
module mod_shift_reg
    import mod_shift_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int WW = WW_DEF,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_cnt,
    input  logic [WW-1:0] word_in,
    input  logic          ser_in,
    input  logic          stall,
    output logic [DW-1:0] regout,
    output logic          shout,
    output logic          busy,
    output logic          done,
    output logic          zero
);
    logic [DW-1:0] r_reg;
    logic          r_shout;

    logic          w_accept;
    logic          w_shift_en;
    logic          w_left;

    mod_shift_ctrl #(
        .DW (DW),
        .CW (CW)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (cmd_valid),
        .i_cmd_op     (cmd_op),
        .i_cmd_cnt    (cmd_cnt),
        .i_stall      (stall),
        .o_cmd_ready  (cmd_ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_accept     (w_accept),
        .o_shift_en   (w_shift_en),
        .o_shift_left (w_left)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg   <= '0;
            r_shout <= 1'b0;
        end else if (w_accept && (cmd_op == OP_LOAD)) begin
            r_reg <= {word_in, r_reg[DW-1:WW]};
        end else if (w_accept && (cmd_op == OP_CLR)) begin
            r_reg   <= '0;
            r_shout <= 1'b0;
        end else if (w_shift_en) begin
            // The bit falling off the end lands in shout.
            if (w_left) {r_shout, r_reg} <= {r_reg, ser_in};
            else        {r_reg, r_shout} <= {ser_in, r_reg};
        end
    end

    assign regout = r_reg;
    assign shout  = r_shout;
    assign zero   = (r_reg == '0);
endmodule
